// File: rtl/vga_line_prefetch.sv
// Double-buffered scan-line store: fetches line n+1 from a valid/ready pixel source
// while line n is displayed, and flags lines shown before their fetch completed.
module vga_line_prefetch #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int V_LAST   = 666,
  parameter int CNT_W    = 11,
  parameter int LINE_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  count,
  input  logic [LINE_W-1:0] reset_count,
  output logic              line_req,
  output logic [LINE_W-1:0] line_num,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [23:0]       wr_data,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int AW = $clog2(H_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_fc [2];
  logic [23:0]       r_bank [2][H_ACTIVE];
  logic              r_line_req;
  logic [LINE_W-1:0] r_line_num;
  logic              r_underrun;
  logic [23:0]       r_pix_p1;
  logic              r_vld_p1;

  logic              w_trig;
  logic [LINE_W-1:0] w_target;
  logic              w_fill;
  logic              w_acc;
  logic              w_wbank;
  logic [CNT_W-1:0]  w_fc_cur;
  logic              w_rbank;
  logic              w_vis;
  logic              w_hit;
  logic              w_set_under;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(H_ACTIVE)) ? v : v + 1'b1;
  endfunction

  // Fetch one line ahead; the last line of the frame pre-loads line 0.
  assign w_trig   = (count == '0) &&
                    ((reset_count == LINE_W'(V_LAST)) || (reset_count < LINE_W'(V_ACTIVE - 1)));
  assign w_target = (reset_count == LINE_W'(V_LAST)) ? '0 : reset_count + 1'b1;

  assign w_fill   = (r_state == S_FILL);
  assign wr_ready = w_fill && !w_trig;
  assign w_acc    = wr_valid && wr_ready;
  assign w_wbank  = r_line_num[0];
  assign w_fc_cur = r_fc[w_wbank];

  assign w_rbank     = reset_count[0];
  assign w_vis       = (count < CNT_W'(H_ACTIVE)) && (reset_count < LINE_W'(V_ACTIVE));
  assign w_hit       = w_vis && (count < r_fc[w_rbank]);
  assign w_set_under = (w_trig && w_fill) || (w_vis && !w_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fc[0]    <= '0;
      r_fc[1]    <= '0;
      r_line_req <= 1'b0;
      r_line_num <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_line_req <= w_trig;
      if (w_set_under)       r_underrun <= 1'b1;
      else if (underrun_clr) r_underrun <= 1'b0;

      // A new trigger aborts any fetch still in progress; its fill count stays frozen.
      if (w_trig) begin
        r_line_num         <= w_target;
        r_fc[w_target[0]]  <= '0;
        r_state            <= S_FILL;
      end else begin
        case (r_state)
          S_FILL: begin
            if (w_acc) begin
              r_fc[w_wbank] <= sat_inc(w_fc_cur);
              if (w_fc_cur == CNT_W'(H_ACTIVE - 1)) r_state <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // ---- stage p1: bank write and registered display read ----
  always_ff @(posedge clk) begin
    if (w_acc) r_bank[w_wbank][w_fc_cur[AW-1:0]] <= wr_data;
    r_pix_p1 <= r_bank[w_rbank][count[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= w_hit;
  end

  assign line_req = r_line_req;
  assign line_num = r_line_num;
  assign underrun = r_underrun;
  assign red      = r_vld_p1 ? r_pix_p1[23:16] : 8'h00;
  assign green    = r_vld_p1 ? r_pix_p1[15:8]  : 8'h00;
  assign blue     = r_vld_p1 ? r_pix_p1[7:0]   : 8'h00;

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Directed bench for vga_line_prefetch: a line-level reference model feeds a queue of
// expected pixels that is compared against the registered RGB output.
module tb_vga_line_prefetch;

  localparam int HA = 800;
  localparam int VA = 600;
  localparam int VL = 666;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] count;
  logic [9:0]  reset_count;
  logic        line_req;
  logic [9:0]  line_num;
  logic        wr_valid;
  logic        wr_ready;
  logic [23:0] wr_data;
  logic [7:0]  red, green, blue;
  logic        underrun;
  logic        underrun_clr;

  always #5 clk = ~clk;

  vga_line_prefetch dut (
    .clk(clk), .rst(rst), .count(count), .reset_count(reset_count),
    .line_req(line_req), .line_num(line_num), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .red(red), .green(green),
    .blue(blue), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] q_exp [$];

  int          m_state;
  int          m_fc [2];
  logic [23:0] m_mem [2][HA];
  int          m_line;
  bit          m_under;
  bit          m_lreq;
  int          src_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int c, input int rc, input bit clr);
    bit trig, ready, vis, set_u, acc;
    int tgt, b;
    logic [23:0] e, d;
    rst          = 1'b0;
    count        = 11'(c);
    reset_count  = 10'(rc);
    underrun_clr = clr;
    wr_valid     = (src_mode == 2) ? 1'($urandom_range(0, 1)) : (src_mode == 1);
    d            = {8'(m_line), 16'(m_fc[m_line & 1])};
    wr_data      = d;
    #1;
    trig  = (c == 0) && (rc == VL || rc < VA - 1);
    tgt   = (rc == VL) ? 0 : rc + 1;
    ready = (m_state == 1) && !trig;
    chk("wr_ready", wr_ready, ready);
    b     = rc & 1;
    vis   = (c < HA) && (rc < VA);
    e     = (vis && c < m_fc[b]) ? m_mem[b][c] : 24'h0;
    q_exp.push_back(e);
    set_u = (trig && m_state == 1) || (vis && c >= m_fc[b]);
    acc   = wr_valid && ready;
    @(posedge clk);
    #1;
    m_under = set_u ? 1'b1 : (clr ? 1'b0 : m_under);
    m_lreq  = trig;
    if (trig) begin
      m_fc[tgt & 1] = 0;
      m_line        = tgt;
      m_state       = 1;
    end else if (m_state == 1) begin
      if (acc) begin
        m_mem[m_line & 1][m_fc[m_line & 1]] = d;
        m_fc[m_line & 1]++;
        if (m_fc[m_line & 1] == HA) m_state = 2;
      end
    end else if (m_state == 2) begin
      m_state = 0;
    end
    chk("rgb", {red, green, blue}, q_exp.pop_front());
    chk("line_req", line_req, m_lreq);
    if (m_lreq) chk("line_num", line_num, m_line);
    chk("underrun", underrun, m_under);
  endtask

  task automatic run_line(input int rc);
    for (int c = 0; c <= 1040; c++) tick(c, rc, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst          = 1'b1;
    count        = 11'd0;
    reset_count  = 10'd700;
    wr_valid     = 1'b0;
    wr_data      = 24'h0;
    underrun_clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    m_state = 0;
    m_fc[0] = 0;
    m_fc[1] = 0;
    m_line  = 0;
    m_under = 1'b0;
    m_lreq  = 1'b0;
    q_exp.delete();
    chk("rst_rgb", {red, green, blue}, 24'h0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_line_req", line_req, 1'b0);
    chk("rst_line_num", line_num, 10'd0);
    chk("rst_underrun", underrun, 1'b0);
  endtask

  initial begin
    int c;
    src_mode = 1;
    do_reset(3);

    // Frame priming: line 0 fetched during line 666, pixel 5 of line 0 reads 0x000005.
    run_line(666);
    for (int i = 0; i <= 5; i++) tick(i, 0, 1'b0);
    chk("prime_px5", {red, green, blue}, 24'h000005);
    chk("prime_underrun", underrun, 1'b0);
    for (int i = 6; i <= 1040; i++) tick(i, 0, 1'b0);
    for (int i = 0; i <= 3; i++) tick(i, 1, 1'b0);
    chk("pingpong_px3", {red, green, blue}, 24'h010003);
    for (int i = 4; i <= 1040; i++) tick(i, 1, 1'b0);
    run_line(2);
    run_line(3);
    chk("pingpong_underrun", underrun, 1'b0);

    // Blanking and the bottom-of-frame trigger gap.
    run_line(597);
    run_line(598);
    run_line(599);
    run_line(600);
    run_line(665);
    run_line(666);

    // Backpressure: 50% source cannot keep up with a 1041-cycle line.
    src_mode = 2;
    run_line(0);
    run_line(1);
    chk("bp_underrun", underrun, 1'b1);
    run_line(2);

    // Clear collision, then clear alone.
    tick(799, 3, 1'b1);
    chk("clr_collide", underrun, 1'b1);
    tick(5, 700, 1'b1);
    chk("clr_alone", underrun, 1'b0);
    tick(6, 700, 1'b0);

    // Reset in the middle of a fetch.
    src_mode = 1;
    tick(0, 666, 1'b0);
    c = 1;
    while (m_fc[0] < 300 && c <= 1040) begin
      tick(c, 666, 1'b0);
      c++;
    end
    chk("mid_accepts", dut.r_fc[0], 11'd300);
    do_reset(1);
    src_mode = 0;
    for (int i = 0; i <= 10; i++) tick(i, 0, 1'b0);
    chk("post_rst_px", {red, green, blue}, 24'h0);
    for (int i = 11; i <= 20; i++) tick(i, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
